// File: rtl/xor_decode_match_pkg.sv
// xor_decode_match_pkg: opt encodings, entry field layout and counter helper for the hash lookup.
// Entry layout: bit [DATA_WIDTH-1] valid, [KEY_WIDTH-1:0] key, the bits between are the value.
package xor_decode_match_pkg;

    typedef enum logic [1:0] {
        OPT_IDLE   = 2'd0,
        OPT_SEARCH = 2'd1,
        OPT_INSERT = 2'd2,
        OPT_DELETE = 2'd3
    } opt_e;

    localparam int KEY_LSB = 0;

    function automatic int valid_bit(input int data_width);
        return data_width - 1;
    endfunction

    function automatic int value_lsb(input int key_width);
        return key_width;
    endfunction

    // Saturating increment: a counter parked at all-ones stays there.
    function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
        return (en && c != 32'hFFFF_FFFF) ? c + 32'd1 : c;
    endfunction

endpackage

// File: rtl/xor_decode_match_lowest_set_enc.sv
// lowest_set_enc: priority encoder returning the lowest set bit index.
// Ports: vec_i request vector; idx_o lowest set index (0 when none); found_o any bit set.
module lowest_set_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);
    always_comb begin
        idx_o   = '0;
        found_o = |vec_i;
        for (int i = N - 1; i >= 0; i--)
            if (vec_i[i]) idx_o = W'(i);
    end
endmodule

// File: rtl/xor_decode_match.sv
// xor_decode_match: 3-stage XOR-decode, key match and slot selection for a multi-way hash row.
// Ports: clk/reset (sync, active-high); in_all banked row data, in_key, in_opt request;
// res_* lookup result 3 cycles later; cnt_hit/cnt_miss/cnt_full saturating statistics.
module xor_decode_match
    import xor_decode_match_pkg::*;
#(
    parameter int NUM_MUL    = 4,
    parameter int NUM_WR     = 8,
    parameter int DATA_WIDTH = 64,
    parameter int KEY_WIDTH  = 32,
    parameter int SLOT_WIDTH = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  in_all,
    input  logic [KEY_WIDTH-1:0]                  in_key,
    input  logic [1:0]                            in_opt,
    output logic                                  res_valid,
    output logic [1:0]                            res_opt,
    output logic [KEY_WIDTH-1:0]                  res_key,
    output logic                                  res_hit,
    output logic [SLOT_WIDTH-1:0]                 res_slot,
    output logic [DATA_WIDTH-1-KEY_WIDTH-1:0]     res_value,
    output logic                                  res_free_valid,
    output logic [SLOT_WIDTH-1:0]                 res_free_slot,
    output logic                                  res_full,
    output logic                                  res_dup,
    output logic [31:0]                           cnt_hit,
    output logic [31:0]                           cnt_miss,
    output logic [31:0]                           cnt_full
);
    localparam int VB = valid_bit(DATA_WIDTH);
    localparam int VL = value_lsb(KEY_WIDTH);
    localparam int VW = DATA_WIDTH - 1 - KEY_WIDTH;

    // Stage 1: XOR-fold the write banks per slot.
    logic [DATA_WIDTH-1:0] row_d [NUM_MUL];
    logic [DATA_WIDTH-1:0] row_q [NUM_MUL];
    logic [KEY_WIDTH-1:0]  key1_q;
    opt_e                  opt1_q;

    always_comb begin
        for (int m = 0; m < NUM_MUL; m++) begin
            row_d[m] = '0;
            for (int w = 0; w < NUM_WR; w++)
                row_d[m] = row_d[m] ^ in_all[(w*NUM_MUL+m)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Stage 2: per-slot match/empty vectors; only the value field travels on.
    logic [NUM_MUL-1:0]   match_d, empty_d, match_q, empty_q;
    logic [VW-1:0]        val_d [NUM_MUL];
    logic [VW-1:0]        val_q [NUM_MUL];
    logic [KEY_WIDTH-1:0] key2_q;
    opt_e                 opt2_q;

    always_comb begin
        match_d = '0;
        empty_d = '0;
        val_d   = '{default: '0};
        for (int m = 0; m < NUM_MUL; m++) begin
            match_d[m] = row_q[m][VB] && (row_q[m][KEY_LSB +: KEY_WIDTH] == key1_q);
            empty_d[m] = !row_q[m][VB];
            val_d[m]   = row_q[m][VL +: VW];
        end
    end

    // Stage 3: priority selection and result formation.
    logic [SLOT_WIDTH-1:0] hit_slot, free_slot;
    logic                  hit_found, free_found;

    lowest_set_enc #(.N(NUM_MUL), .W(SLOT_WIDTH)) u_hit_enc (
        .vec_i   (match_q),
        .idx_o   (hit_slot),
        .found_o (hit_found)
    );

    lowest_set_enc #(.N(NUM_MUL), .W(SLOT_WIDTH)) u_free_enc (
        .vec_i   (empty_q),
        .idx_o   (free_slot),
        .found_o (free_found)
    );

    logic                  hit_d, full_d, dup_d;
    logic [VW-1:0]         value_d;
    logic [31:0]           cnt_hit_d, cnt_miss_d, cnt_full_d;

    logic                  res_hit_q, res_free_valid_q, res_full_q, res_dup_q;
    opt_e                  res_opt_q;
    logic [KEY_WIDTH-1:0]  res_key_q;
    logic [SLOT_WIDTH-1:0] res_slot_q, res_free_slot_q;
    logic [VW-1:0]         res_value_q;
    logic [31:0]           cnt_hit_q, cnt_miss_q, cnt_full_q;

    always_comb begin
        hit_d      = (opt2_q != OPT_IDLE) && hit_found;
        full_d     = (opt2_q == OPT_INSERT) && !hit_found && !free_found;
        dup_d      = (opt2_q == OPT_INSERT) && hit_found;
        value_d    = hit_found ? val_q[hit_slot] : '0;
        cnt_hit_d  = sat_inc(cnt_hit_q, (opt2_q == OPT_SEARCH) && hit_found);
        cnt_miss_d = sat_inc(cnt_miss_q, (opt2_q == OPT_SEARCH) && !hit_found);
        cnt_full_d = sat_inc(cnt_full_q, full_d);
    end

    // Data/key path: no reset needed, qualified by the opt fields.
    always_ff @(posedge clk) begin
        row_q           <= row_d;
        key1_q          <= in_key;
        match_q         <= match_d;
        empty_q         <= empty_d;
        val_q           <= val_d;
        key2_q          <= key1_q;
        res_key_q       <= key2_q;
        res_slot_q      <= hit_found ? hit_slot : '0;
        res_value_q     <= value_d;
        res_free_slot_q <= free_slot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opt1_q           <= OPT_IDLE;
            opt2_q           <= OPT_IDLE;
            res_opt_q        <= OPT_IDLE;
            res_hit_q        <= 1'b0;
            res_free_valid_q <= 1'b0;
            res_full_q       <= 1'b0;
            res_dup_q        <= 1'b0;
            cnt_hit_q        <= '0;
            cnt_miss_q       <= '0;
            cnt_full_q       <= '0;
        end else begin
            opt1_q           <= opt_e'(in_opt);
            opt2_q           <= opt1_q;
            res_opt_q        <= opt2_q;
            res_hit_q        <= hit_d;
            res_free_valid_q <= free_found;
            res_full_q       <= full_d;
            res_dup_q        <= dup_d;
            cnt_hit_q        <= cnt_hit_d;
            cnt_miss_q       <= cnt_miss_d;
            cnt_full_q       <= cnt_full_d;
        end
    end

    assign res_valid      = res_opt_q != OPT_IDLE;
    assign res_opt        = res_opt_q;
    assign res_key        = res_key_q;
    assign res_hit        = res_hit_q;
    assign res_slot       = res_slot_q;
    assign res_value      = res_value_q;
    assign res_free_valid = res_free_valid_q;
    assign res_free_slot  = res_free_slot_q;
    assign res_full       = res_full_q;
    assign res_dup        = res_dup_q;
    assign cnt_hit        = cnt_hit_q;
    assign cnt_miss       = cnt_miss_q;
    assign cnt_full       = cnt_full_q;
endmodule

// File: tb/tb_xor_decode_match.sv
// tb_xor_decode_match: directed self-checking bench for xor_decode_match (default parameters).
module tb_xor_decode_match;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2047:0] in_all = '0;
    logic [31:0]   in_key = '0;
    logic [1:0]    in_opt = 2'd0;
    logic          res_valid, res_hit, res_free_valid, res_full, res_dup;
    logic [1:0]    res_opt;
    logic [31:0]   res_key;
    logic [1:0]    res_slot, res_free_slot;
    logic [30:0]   res_value;
    logic [31:0]   cnt_hit, cnt_miss, cnt_full;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    xor_decode_match dut (
        .clk(clk), .reset(reset), .in_all(in_all), .in_key(in_key), .in_opt(in_opt),
        .res_valid(res_valid), .res_opt(res_opt), .res_key(res_key), .res_hit(res_hit),
        .res_slot(res_slot), .res_value(res_value), .res_free_valid(res_free_valid),
        .res_free_slot(res_free_slot), .res_full(res_full), .res_dup(res_dup),
        .cnt_hit(cnt_hit), .cnt_miss(cnt_miss), .cnt_full(cnt_full)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [63:0] ent(input logic v, input logic [30:0] val, input logic [31:0] k);
        return {v, val, k};
    endfunction

    // Spread each wanted entry over 8 banks: banks 1..7 random, bank 0 closes the XOR.
    task automatic load_row(input logic [63:0] e0, input logic [63:0] e1,
                            input logic [63:0] e2, input logic [63:0] e3);
        logic [63:0] e [4];
        logic [63:0] acc, r;
        e = '{e0, e1, e2, e3};
        for (int m = 0; m < 4; m++) begin
            acc = e[m];
            for (int w = 1; w < 8; w++) begin
                r = {$urandom, $urandom};
                in_all[(w*4+m)*64 +: 64] = r;
                acc = acc ^ r;
            end
            in_all[m*64 +: 64] = acc;
        end
    endtask

    // Issue one op and land on the negedge where its result is visible.
    task automatic run1(input logic [1:0] opt, input logic [31:0] key);
        in_opt = opt;
        in_key = key;
        tick();
        in_opt = 2'd0;
        tick();
        tick();
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_valid", res_valid, 0);
        chk("rst_hit", res_hit, 0);
        chk("rst_cnt_hit", cnt_hit, 0);
        chk("rst_cnt_full", cnt_full, 0);

        // Hit in slot 2 (slot 1 empty).
        load_row(ent(1, 31'h11, 32'h1), ent(0, 31'h0, 32'h0),
                 ent(1, 31'h1234, 32'hDEADBEEF), ent(1, 31'h22, 32'h2));
        run1(2'd1, 32'hDEADBEEF);
        chk("s_valid", res_valid, 1);
        chk("s_opt", res_opt, 1);
        chk("s_key", res_key, 32'hDEADBEEF);
        chk("s_hit", res_hit, 1);
        chk("s_slot", res_slot, 2);
        chk("s_value", res_value, 31'h1234);
        chk("s_cnt_hit", cnt_hit, 1);
        chk("s_free_slot", res_free_slot, 1);

        // Full row, insert of an absent key.
        load_row(ent(1, 31'h1, 32'h10), ent(1, 31'h2, 32'h11),
                 ent(1, 31'h3, 32'h12), ent(1, 31'h4, 32'h13));
        run1(2'd2, 32'h5);
        chk("f_full", res_full, 1);
        chk("f_hit", res_hit, 0);
        chk("f_free_valid", res_free_valid, 0);
        chk("f_free_slot", res_free_slot, 0);
        chk("f_dup", res_dup, 0);
        chk("f_value", res_value, 0);
        chk("f_cnt_full", cnt_full, 1);

        // Slots 1 and 3 empty, insert of a new key.
        load_row(ent(1, 31'h5, 32'h20), ent(0, 31'h7, 32'h99),
                 ent(1, 31'h6, 32'h21), ent(0, 31'h0, 32'h0));
        run1(2'd2, 32'h99);
        chk("i_free_valid", res_free_valid, 1);
        chk("i_free_slot", res_free_slot, 1);
        chk("i_dup", res_dup, 0);
        chk("i_full", res_full, 0);
        chk("i_hit", res_hit, 0);
        chk("i_cnt_full", cnt_full, 1);

        // Corrupt row: key present in slots 1 and 3, lowest wins; insert flags dup.
        load_row(ent(1, 31'h1, 32'h76), ent(1, 31'h4AA, 32'h77),
                 ent(0, 31'h0, 32'h0), ent(1, 31'h4BB, 32'h77));
        run1(2'd2, 32'h77);
        chk("d_dup", res_dup, 1);
        chk("d_hit", res_hit, 1);
        chk("d_slot", res_slot, 1);
        chk("d_value", res_value, 31'h4AA);
        chk("d_full", res_full, 0);
        chk("d_free_slot", res_free_slot, 2);

        // Back-to-back search, insert, delete, idle.
        load_row(ent(1, 31'h11, 32'h1), ent(0, 31'h0, 32'h0),
                 ent(1, 31'h1234, 32'hDEADBEEF), ent(1, 31'h22, 32'h2));
        in_opt = 2'd1; in_key = 32'hDEADBEEF; tick();
        in_opt = 2'd2; in_key = 32'hDEADBEEF; tick();
        in_opt = 2'd3; in_key = 32'h55;       tick();
        chk("b0_opt", res_opt, 1);
        chk("b0_hit", res_hit, 1);
        chk("b0_slot", res_slot, 2);
        in_opt = 2'd0; in_key = 32'hDEADBEEF; tick();
        chk("b1_opt", res_opt, 2);
        chk("b1_dup", res_dup, 1);
        chk("b1_cnt_hit", cnt_hit, 2);
        tick();
        chk("b2_opt", res_opt, 3);
        chk("b2_valid", res_valid, 1);
        chk("b2_key", res_key, 32'h55);
        chk("b2_hit", res_hit, 0);
        chk("b2_dup", res_dup, 0);
        tick();
        chk("b3_valid", res_valid, 0);
        chk("b3_hit", res_hit, 0);
        chk("b3_full", res_full, 0);
        chk("b3_dup", res_dup, 0);
        chk("b3_cnt_hit", cnt_hit, 2);
        chk("b3_cnt_miss", cnt_miss, 0);

        // Saturation of cnt_miss.
        force dut.cnt_miss_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_miss_q;
        tick();
        chk("m_preload", cnt_miss, 32'hFFFF_FFFE);
        in_opt = 2'd1; in_key = 32'h999; tick();
        tick(); tick();
        in_opt = 2'd0;
        chk("m_first", cnt_miss, 32'hFFFF_FFFF);
        chk("m_first_hit", res_hit, 0);
        tick();
        chk("m_second", cnt_miss, 32'hFFFF_FFFF);
        tick();
        chk("m_third", cnt_miss, 32'hFFFF_FFFF);
        chk("m_third_valid", res_valid, 1);

        // Reset one cycle after a search is issued.
        tick(); tick();
        in_opt = 2'd1; in_key = 32'hDEADBEEF; tick();
        in_opt = 2'd0; reset = 1'b1; tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("r_valid", res_valid, 0);
            tick();
        end
        chk("r_cnt_hit", cnt_hit, 0);
        chk("r_cnt_miss", cnt_miss, 0);
        chk("r_cnt_full", cnt_full, 0);
        in_opt = 2'd1; in_key = 32'hDEADBEEF; tick();
        in_opt = 2'd0; tick();
        chk("r_lat2_valid", res_valid, 0);
        tick();
        chk("r_lat3_valid", res_valid, 1);
        chk("r_lat3_hit", res_hit, 1);
        chk("r_lat3_cnt_hit", cnt_hit, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/xor_decode_match.md
XOR_DECODE_MATCH -- requirements
Module: xor_decode_match

Interface
REQ-001 SHALL have parameter NUM_MUL, default 4, meaning slots (ways) per hash row.
REQ-002 SHALL have parameter NUM_WR, default 8, meaning write-port banks whose outputs are XOR-combined.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, meaning width of one stored entry.
REQ-004 SHALL have parameter KEY_WIDTH, default 32, meaning key width.
REQ-005 SHALL have parameter SLOT_WIDTH, default 2, meaning slot index width, equal to clog2(NUM_MUL).
REQ-006 SHALL have port clk, input, 1, meaning clock.
REQ-007 SHALL have port reset, input, 1, meaning reset, synchronous, active-high.
REQ-008 SHALL have port in_all, input, NUM_MUL*NUM_WR*DATA_WIDTH, meaning row-stage read data; bank w, slot m sits at offset (w*NUM_MUL+m)*DATA_WIDTH.
REQ-009 SHALL have port in_key, input, KEY_WIDTH, meaning lookup key aligned with in_all.
REQ-010 SHALL have port in_opt, input, 2, meaning 0 idle, 1 search, 2 insert, 3 delete.
REQ-011 SHALL have port res_valid, output, 1, meaning result present, high when res_opt is nonzero.
REQ-012 SHALL have port res_opt, output, 2, meaning delayed in_opt.
REQ-013 SHALL have port res_key, output, KEY_WIDTH, meaning delayed in_key.
REQ-014 SHALL have port res_hit, output, 1, meaning key found.
REQ-015 SHALL have port res_slot, output, SLOT_WIDTH, meaning matching slot.
REQ-016 SHALL have port res_value, output, DATA_WIDTH-1-KEY_WIDTH, meaning value of the matching entry.
REQ-017 SHALL have port res_free_valid, output, 1, meaning an empty slot exists.
REQ-018 SHALL have port res_free_slot, output, SLOT_WIDTH, meaning lowest empty slot.
REQ-019 SHALL have port res_full, output, 1, meaning insert with no hit and no free slot.
REQ-020 SHALL have port res_dup, output, 1, meaning insert whose key is already present.
REQ-021 SHALL have ports cnt_hit, cnt_miss and cnt_full, each output, 32, meaning saturating statistics counters.

Function
REQ-022 SHALL treat an entry as follows: bit DATA_WIDTH-1 is valid, bits [KEY_WIDTH-1:0] are key, and the remaining bits are value.
REQ-023 SHALL, in stage 1, register for each slot m the XOR over all NUM_WR banks of slot m, together with in_key and in_opt.
REQ-024 SHALL, in stage 2, register per-slot match (valid and key equal) and per-slot empty (valid==0) vectors, together with the decoded entries.
REQ-025 SHALL, in stage 3, priority-encode the lowest-index match and lowest-index empty slot and register all res_* outputs; latency is exactly 3 cycles, with one new operation accepted every cycle.
REQ-026 SHALL drive res_slot=0 and res_value=0 when there is no match.
REQ-027 SHALL drive res_free_slot=0 when res_free_valid=0.
REQ-028 SHALL assert res_full only for opt=2 with no hit and no empty slot.
REQ-029 SHALL assert res_dup only for opt=2 with a hit.
REQ-030 SHALL force res_hit, res_full and res_dup to 0 for opt=0; the other outputs are don't-care but deterministic.
REQ-031 SHALL increment cnt_hit in the cycle a search result with res_hit=1 is output.
REQ-032 SHALL increment cnt_miss in the cycle a search result with res_hit=0 is output.
REQ-033 SHALL increment cnt_full in the cycle an insert result with res_full=1 is output.
REQ-034 SHALL hold each counter at 0xFFFFFFFF once it reaches that value.
REQ-035 SHALL, for multiple matching slots (corrupt row), report the lowest index and raise no error.

Reset
REQ-036 SHALL, while reset is high, clear all stage opt fields, res_valid, res_opt, res_hit, res_free_valid, res_full, res_dup and all counters to 0.
REQ-037 SHALL not reset data and key pipeline registers.
REQ-038 SHALL, on reset asserted mid-operation, discard all in-flight operations; the first valid result appears 3 cycles after the first valid input following reset deassertion.

Structure
REQ-039 SHALL place the opt encodings (OPT_IDLE, OPT_SEARCH, OPT_INSERT, OPT_DELETE) and the entry field offsets in the shared hash package.
REQ-040 SHALL place the priority encoder in sub-module lowest_set_enc (NUM_MUL to SLOT_WIDTH plus found flag), instantiated twice.

Verification (NUM_MUL=4, NUM_WR=8, DATA_WIDTH=64, KEY_WIDTH=32)
REQ-041 SHALL cover: slot 2 XOR-decodes to valid, key 0xDEADBEEF, value 0x1234, with search key 0xDEADBEEF -> 3 cycles later res_hit=1, res_slot=2, res_value=0x1234, cnt_hit=1.
REQ-042 SHALL cover: all slots valid, non-matching keys, insert key 0x5 -> res_full=1, res_hit=0, res_free_valid=0, cnt_full=1.
REQ-043 SHALL cover: slots 1 and 3 empty, insert of a new key -> res_free_valid=1, res_free_slot=1, res_dup=0.
REQ-044 SHALL cover: back-to-back search, insert, delete, idle on 4 consecutive cycles -> results on 4 consecutive cycles in order; the idle cycle has res_valid=0.
REQ-045 SHALL cover: cnt_miss preloaded to 0xFFFFFFFE, 3 search misses -> cnt_miss holds 0xFFFFFFFF.
REQ-046 SHALL cover: reset asserted 1 cycle after a search is issued -> no res_valid for that search; counters read 0.
